// File: rtl/two_cpl_pipe_if.sv
// Handshake bundle for two_cpl_pipe: input word/mode with valid/ready, result/overflow with
// valid/ready. The slave modport is the unit's view; master is the producer/consumer view.
interface two_cpl_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid,
    output in_data,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_ovf
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_ovf
  );
endinterface

// File: rtl/two_cpl_pipe.sv
// Pipelined pass/negate/abs/-abs of a signed word, carry chain cut into SEG-bit slices with
// one stage per slice. Define TWO_CPL_SAT_EN to clamp overflowing results to max positive.
module two_cpl_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input logic           clk,
  input logic           rst,
  two_cpl_pipe_if.slave bus
);

  localparam int unsigned NSTG = (SEG == 0) ? 1 : WIDTH / SEG;
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH - 1){1'b0}}};
`ifdef TWO_CPL_SAT_EN
  localparam logic [WIDTH-1:0] MaxPos = ~MinNeg;
`endif

  if (WIDTH < 2) begin : g_chk_width
    $error("two_cpl_pipe: WIDTH must be at least 2");
  end
  if ((SEG == 0) || ((WIDTH % ((SEG == 0) ? 1 : SEG)) != 0)) begin : g_chk_seg
    $error("two_cpl_pipe: WIDTH must be a non-zero multiple of SEG");
  end

  // Per-stage state: each stage holds the word with its own slice already resolved,
  // plus the carry into the next slice.
  logic [NSTG-1:0]            vld_q, vld_d;
  logic [NSTG-1:0][WIDTH-1:0] data_q, data_d;
  logic [NSTG-1:0]            neg_q, neg_d;
  logic [NSTG-1:0]            ovf_q, ovf_d;
  logic [NSTG-1:0]            cy_q, cy_d;

  logic in_msb, in_neg, in_ovf;

  always_comb begin
    in_msb = bus.in_data[WIDTH-1];
    case (bus.in_mode)
      2'b00:   in_neg = 1'b0;
      2'b01:   in_neg = 1'b1;
      2'b10:   in_neg = in_msb;
      2'b11:   in_neg = ~in_msb;
      default: in_neg = 1'b0;
    endcase
    in_ovf = in_neg & (bus.in_data == MinNeg);
  end

  // A stage advances when it or any stage downstream of it is empty, or the consumer takes
  // the result; computed as a suffix AND so no signal feeds back into itself.
  logic [NSTG-1:0] adv;
  logic            tail_full;

  always_comb begin
    tail_full = 1'b1;
    adv       = '0;
    for (int k = int'(NSTG) - 1; k >= 0; k--) begin
      tail_full = tail_full & vld_q[k];
      adv[k]    = bus.out_ready | ~tail_full;
    end
  end

  logic [NSTG-1:0]            src_vld, src_neg, src_ovf, src_cy;
  logic [NSTG-1:0][WIDTH-1:0] src_data;

  always_comb begin
    src_vld[0]  = bus.in_valid;
    src_data[0] = bus.in_data;
    src_neg[0]  = in_neg;
    src_ovf[0]  = in_ovf;
    src_cy[0]   = in_neg;
    for (int k = 1; k < int'(NSTG); k++) begin
      src_vld[k]  = vld_q[k-1];
      src_data[k] = data_q[k-1];
      src_neg[k]  = neg_q[k-1];
      src_ovf[k]  = ovf_q[k-1];
      src_cy[k]   = cy_q[k-1];
    end
  end

  logic [SEG:0]     sum;
  logic [WIDTH-1:0] res;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
    cy_d   = cy_q;
    sum    = '0;
    res    = '0;
    for (int k = 0; k < int'(NSTG); k++) begin
      sum = {1'b0, src_data[k][k*SEG +: SEG] ^ {SEG{src_neg[k]}}} + {{SEG{1'b0}}, src_cy[k]};
      res = src_data[k];
      res[k*SEG +: SEG] = sum[SEG-1:0];
`ifdef TWO_CPL_SAT_EN
      if ((k == int'(NSTG) - 1) && src_ovf[k]) begin
        res = MaxPos;
      end
`endif
      if (adv[k]) begin
        vld_d[k]  = src_vld[k];
        data_d[k] = res;
        neg_d[k]  = src_neg[k];
        ovf_d[k]  = src_ovf[k];
        cy_d[k]   = sum[SEG];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      data_q <= '0;
      neg_q  <= '0;
      ovf_q  <= '0;
      cy_q   <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
      cy_q   <= cy_d;
    end
  end

  // Carry out of the top slice is dropped; the last stage's sign control has no consumer.
  logic unused_tail;
  assign unused_tail = cy_q[NSTG-1] ^ neg_q[NSTG-1];

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = vld_q[NSTG-1];
  assign bus.out_data  = data_q[NSTG-1];
  assign bus.out_ovf   = ovf_q[NSTG-1];

endmodule

// File: tb/tb_two_cpl_pipe.sv
// Bench for two_cpl_pipe: three instances (16/4, 24/8, 8/8) checked against a signed-integer
// reference model; directed boundary cases, streaming, stalls, random handshakes and reset.
module tb_two_cpl_pipe;

  localparam int NU = 3;
`ifdef TWO_CPL_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  int width_tab [NU] = '{16, 24, 8};
  int nstg_tab  [NU] = '{4, 3, 1};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_v   [NU];
  logic [31:0] in_d   [NU];
  logic [1:0]  in_m   [NU];
  logic        out_r  [NU];
  logic        in_rdy [NU];
  logic        out_v  [NU];
  logic [31:0] out_d  [NU];
  logic        out_o  [NU];

  two_cpl_pipe_if #(.WIDTH(16)) if0 ();
  two_cpl_pipe_if #(.WIDTH(24)) if1 ();
  two_cpl_pipe_if #(.WIDTH(8))  if2 ();

  two_cpl_pipe #(.WIDTH(16), .SEG(4)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  two_cpl_pipe #(.WIDTH(24), .SEG(8)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  two_cpl_pipe #(.WIDTH(8),  .SEG(8)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.in_valid  = in_v[0];
  assign if0.in_data   = in_d[0][15:0];
  assign if0.in_mode   = in_m[0];
  assign if0.out_ready = out_r[0];
  assign in_rdy[0]     = if0.in_ready;
  assign out_v[0]      = if0.out_valid;
  assign out_d[0]      = {16'd0, if0.out_data};
  assign out_o[0]      = if0.out_ovf;

  assign if1.in_valid  = in_v[1];
  assign if1.in_data   = in_d[1][23:0];
  assign if1.in_mode   = in_m[1];
  assign if1.out_ready = out_r[1];
  assign in_rdy[1]     = if1.in_ready;
  assign out_v[1]      = if1.out_valid;
  assign out_d[1]      = {8'd0, if1.out_data};
  assign out_o[1]      = if1.out_ovf;

  assign if2.in_valid  = in_v[2];
  assign if2.in_data   = in_d[2][7:0];
  assign if2.in_mode   = in_m[2];
  assign if2.out_ready = out_r[2];
  assign in_rdy[2]     = if2.in_ready;
  assign out_v[2]      = if2.out_valid;
  assign out_d[2]      = {24'd0, if2.out_data};
  assign out_o[2]      = if2.out_ovf;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: interpret the word as a signed integer, apply the operation exactly, then
  // decide representability and wrap (or clamp) back to WIDTH bits. Returns {ovf, data}.
  function automatic logic [32:0] model(input int w, input logic [31:0] d, input logic [1:0] m);
    longint span, half, v, r;
    logic   ovf;
    span = longint'(1) << w;
    half = span / 2;
    v = longint'({32'd0, d}) % span;
    if (v >= half) v = v - span;
    case (m)
      2'd0:    r = v;
      2'd1:    r = -v;
      2'd2:    r = (v < 0) ? -v : v;
      default: r = (v < 0) ? v : -v;
    endcase
    ovf = (r >= half) || (r < -half);
    if (ovf && Sat) r = half - 1;
    r = ((r % span) + span) % span;
    return {ovf, r[31:0]};
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] one;
    one = 32'd1;
    case ($urandom_range(0, 7))
      0:       return one << (w - 1);
      1:       return 32'd0;
      2:       return (one << (w - 1)) - 32'd1;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [32:0] exp_q [NU][$];
  bit          in_x      [NU];
  bit          out_x     [NU];
  bit          stall_chk [NU];
  logic [32:0] stall_val [NU];
  int          cyc = 0;

  // Called at a negedge with inputs already set; samples transfers just before the next
  // posedge, updates the scoreboard and returns at the following negedge.
  task automatic tick();
    logic [32:0] e;
    #1;
    for (int u = 0; u < NU; u++) begin
      in_x[u]  = in_v[u] && in_rdy[u];
      out_x[u] = out_v[u] && out_r[u];
      if (stall_chk[u]) begin
        check($sformatf("u%0d_hold_valid", u), 32'(out_v[u]), 32'd1);
        check($sformatf("u%0d_hold_data", u), {out_o[u], out_d[u][30:0]},
              {stall_val[u][32], stall_val[u][30:0]});
      end
      stall_chk[u] = out_v[u] && !out_r[u];
      stall_val[u] = {out_o[u], out_d[u]};
      if (in_x[u]) exp_q[u].push_back(model(width_tab[u], in_d[u], in_m[u]));
      if (out_x[u]) begin
        if (exp_q[u].size() == 0) begin
          check($sformatf("u%0d_out_expected", u), 32'(exp_q[u].size()), 32'd1);
        end else begin
          e = exp_q[u].pop_front();
          check($sformatf("u%0d_data", u), out_d[u], e[31:0]);
          check($sformatf("u%0d_ovf", u), 32'(out_o[u]), 32'(e[32]));
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  // Single word with out_ready=1: checks in_ready, latency and the result against constants.
  task automatic send_one(input int u, input logic [31:0] d, input logic [1:0] m,
                          input logic [31:0] ed, input logic eo, input string tag);
    int lat;
    bit seen;
    in_v[u] = 1'b1;
    in_d[u] = d;
    in_m[u] = m;
    #1 check({tag, "_rdy"}, 32'(in_rdy[u]), 32'd1);
    @(posedge clk);
    #1;
    in_v[u] = 1'b0;
    in_d[u] = ~d;
    in_m[u] = ~m;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 20) begin
      if (out_v[u]) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(nstg_tab[u]));
    check({tag, "_data"}, out_d[u], ed);
    check({tag, "_ovf"}, 32'(out_o[u]), 32'(eo));
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got, prev, start, at16, acc;
    for (int u = 0; u < NU; u++) begin
      in_v[u] = 1'b0;
      in_d[u] = '0;
      in_m[u] = '0;
      out_r[u] = 1'b1;
      in_x[u] = 1'b0;
      out_x[u] = 1'b0;
      stall_chk[u] = 1'b0;
      stall_val[u] = '0;
    end
    rst = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_v[0]), 32'd0);
    check("rst_out_data", out_d[0], 32'd0);
    check("rst_out_ovf", 32'(out_o[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_in_ready", 32'(in_rdy[0]), 32'd1);
    @(negedge clk);

    // Directed cases on the 16/4 instance.
    send_one(0, 32'h0001, 2'b01, 32'hFFFF, 1'b0, "neg_1");
    send_one(0, 32'h00F0, 2'b01, 32'hFF10, 1'b0, "neg_f0");
    send_one(0, 32'hFFF6, 2'b10, 32'h000A, 1'b0, "abs_m10");
    send_one(0, 32'h000A, 2'b11, 32'hFFF6, 1'b0, "nabs_10");
    send_one(0, 32'h1234, 2'b00, 32'h1234, 1'b0, "pass");
    send_one(0, 32'h8000, 2'b11, 32'h8000, 1'b0, "nabs_min");
    send_one(0, 32'h8000, 2'b01, Sat ? 32'h7FFF : 32'h8000, 1'b1, "neg_min");
    send_one(0, 32'h8000, 2'b10, Sat ? 32'h7FFF : 32'h8000, 1'b1, "abs_min");
    send_one(0, 32'h0000, 2'b01, 32'h0000, 1'b0, "neg_zero");
    send_one(2, 32'h0080, 2'b01, Sat ? 32'h007F : 32'h0080, 1'b1, "w8_neg_min");
    send_one(1, 32'h000001, 2'b01, 32'hFFFFFF, 1'b0, "w24_neg_1");
    @(negedge clk);

    // 16 back-to-back words, consumer always ready.
    sent = 0; got = 0; prev = 0; start = cyc; at16 = -1;
    for (int c = 0; c < 40 && got < 16; c++) begin
      if (sent < 16) begin
        in_v[0] = 1'b1;
        in_d[0] = pick(16);
        in_m[0] = 2'($urandom);
      end else in_v[0] = 1'b0;
      tick();
      if (in_x[0]) begin
        sent++;
        if (sent == 16) at16 = cyc - start;
      end
      if (out_x[0]) begin
        if (got > 0) check("stream_gap", 32'(cyc - prev), 32'd1);
        prev = cyc;
        got++;
      end
    end
    in_v[0] = 1'b0;
    check("stream_in_rate", 32'(at16), 32'd16);
    check("stream_count", 32'(got), 32'd16);

    // Consumer stalls for 6 cycles while the producer keeps offering words.
    out_r[0] = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      if (!in_v[0] || in_x[0]) begin
        in_v[0] = 1'b1;
        in_d[0] = pick(16);
        in_m[0] = 2'($urandom);
      end
      tick();
      if (in_x[0]) acc++;
    end
    check("stall_accept", 32'(acc), 32'd4);
    check("stall_in_ready", 32'(in_rdy[0]), 32'd0);
    out_r[0] = 1'b1;
    #1 check("full_ready_comb", 32'(in_rdy[0]), 32'd1);
    for (int c = 0; c < 12; c++) begin
      if (in_x[0]) in_v[0] = 1'b0;
      tick();
    end
    check("stall_drain", 32'(exp_q[0].size()), 32'd0);

    // Random handshakes on all three instances.
    for (int c = 0; c < 400; c++) begin
      for (int u = 0; u < NU; u++) begin
        out_r[u] = ($urandom_range(0, 3) != 0);
        if (!in_v[u] || in_x[u]) begin
          in_v[u] = ($urandom_range(0, 2) != 0);
          in_d[u] = pick(width_tab[u]);
          in_m[u] = 2'($urandom);
        end
      end
      tick();
    end
    for (int c = 0; c < 40; c++) begin
      for (int u = 0; u < NU; u++) begin
        out_r[u] = 1'b1;
        if (in_x[u]) in_v[u] = 1'b0;
      end
      tick();
    end
    for (int u = 0; u < NU; u++) begin
      check($sformatf("u%0d_rand_drain", u), 32'(exp_q[u].size()), 32'd0);
      check($sformatf("u%0d_rand_idle", u), 32'(in_v[u]), 32'd0);
    end

    // Reset with three words in flight.
    out_r[0] = 1'b0;
    acc = 0;
    for (int c = 0; c < 10 && acc < 3; c++) begin
      if (!in_v[0] || in_x[0]) begin
        in_v[0] = 1'b1;
        in_d[0] = pick(16);
        in_m[0] = 2'($urandom);
      end
      tick();
      if (in_x[0]) acc++;
    end
    in_v[0] = 1'b0;
    tick();
    tick();
    check("pre_rst_valid", 32'(out_v[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_v[0]), 32'd0);
    check("mid_rst_data", out_d[0], 32'd0);
    check("mid_rst_ovf", 32'(out_o[0]), 32'd0);
    for (int u = 0; u < NU; u++) begin
      exp_q[u].delete();
      stall_chk[u] = 1'b0;
      in_x[u] = 1'b0;
      out_r[u] = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_ready", 32'(in_rdy[0]), 32'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("post_rst_no_stale", 32'(out_v[0]), 32'd0);
    end
    send_one(0, 32'h0005, 2'b01, 32'hFFFB, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
